// File: rtl/riscy_exec_units.sv
// riscy_exec_units: RISCY register file, ALU and word-addressed memory.
// Define RISCY_RF_BYPASS_EN for write-first register file reads.
module riscy_exec_units #(
    parameter int MEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rf_raddr1,
    input  logic [4:0]  rf_raddr2,
    input  logic [4:0]  rf_waddr,
    input  logic [31:0] rf_wdata,
    input  logic        rf_we,
    output logic [31:0] rf_rdata1,
    output logic [31:0] rf_rdata2,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic [5:0]  alu_fn,
    output logic [31:0] alu_result,
    output logic        alu_zero,
    output logic        alu_overflow,
    input  logic [31:0] mem_addr,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata
);
    localparam int AW = $clog2(MEM_DEPTH);
`ifdef RISCY_RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    logic [31:0] regs [32];
    logic [31:0] mem [MEM_DEPTH] = '{default: '0};
    logic [AW-1:0] mem_idx;
    logic hit1, hit2;
    logic [31:0] sum, diff;
    logic unused_addr;

    assign hit1 = BYPASS && rf_we && rf_waddr == rf_raddr1;
    assign hit2 = BYPASS && rf_we && rf_waddr == rf_raddr2;
    assign rf_rdata1 = rf_raddr1 == 5'd0 ? '0 : hit1 ? rf_wdata : regs[rf_raddr1];
    assign rf_rdata2 = rf_raddr2 == 5'd0 ? '0 : hit2 ? rf_wdata : regs[rf_raddr2];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (rf_we && rf_waddr != 5'd0) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    // Memory ignores reset: contents survive it and writes still land.
    assign mem_idx = mem_addr[AW-1:0];
    assign unused_addr = ^mem_addr[31:AW];
    assign mem_rdata = mem_re ? mem[mem_idx] : '0;

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= mem_wdata;
    end

    assign sum = alu_a + alu_b;
    assign diff = alu_a - alu_b;
    assign alu_zero = alu_result == 32'd0;

    always_comb begin
        alu_result = '0;
        alu_overflow = 1'b0;
        case (alu_fn)
            6'd0: begin
                alu_result = sum;
                alu_overflow = alu_a[31] == alu_b[31] && sum[31] != alu_a[31];
            end
            6'd1: begin
                alu_result = diff;
                alu_overflow = alu_a[31] != alu_b[31] && diff[31] != alu_a[31];
            end
            6'd2: alu_result = alu_a & alu_b;
            6'd3: alu_result = alu_a | alu_b;
            6'd4: alu_result = alu_a ^ alu_b;
            6'd5: alu_result = ~(alu_a | alu_b);
            6'd6: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            6'd7: alu_result = {31'd0, alu_a < alu_b};
            6'd8: alu_result = alu_a << alu_b[4:0];
            6'd9: alu_result = alu_a >> alu_b[4:0];
            6'd10: alu_result = $signed(alu_a) >>> alu_b[4:0];
            6'd11: alu_result = sum;
            6'd12: alu_result = diff;
            6'd13: alu_result = {alu_b[15:0], 16'd0};
            default: ;
        endcase
    end
endmodule

// File: tb/tb_riscy_exec_units.sv
// tb_riscy_exec_units: randomized self-checking bench for riscy_exec_units
// against an arithmetic reference model of the register file, ALU and memory.
module tb_riscy_exec_units;
    localparam int DEPTH = 1024;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;
`ifdef RISCY_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [4:0] rf_raddr1, rf_raddr2, rf_waddr;
    logic [31:0] rf_wdata, rf_rdata1, rf_rdata2;
    logic rf_we;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [5:0] alu_fn;
    logic alu_zero, alu_overflow;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic mem_re, mem_we;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] ref_rf [32];
    logic [31:0] ref_mem [DEPTH];

    riscy_exec_units #(.MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .rf_we(rf_we),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rst = 1'b0;
        rf_we = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        rf_raddr1 = '0;
        rf_raddr2 = '0;
        mem_we = 1'b0;
        mem_re = 1'b0;
        mem_addr = '0;
        mem_wdata = '0;
        alu_a = '0;
        alu_b = '0;
        alu_fn = '0;
    endtask

    // Expected read value for a port, given what the model holds and the write in flight.
    function automatic logic [31:0] rf_expect(input logic [4:0] ra);
        if (ra == 5'd0) return 32'd0;
        if (BYP && rf_we && rf_waddr == ra) return rf_wdata;
        return ref_rf[ra];
    endfunction

    function automatic void alu_ref(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic ov);
        longint sa, sb, s, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p = longint'(1) << b[4:0];
        r = '0;
        ov = 1'b0;
        case (fn)
            6'd0: begin s = sa + sb; r = s[31:0]; ov = s > MAXS || s < MINS; end
            6'd1: begin s = sa - sb; r = s[31:0]; ov = s > MAXS || s < MINS; end
            6'd2: r = a & b;
            6'd3: r = a | b;
            6'd4: r = a ^ b;
            6'd5: r = ~(a | b);
            6'd6: r = sa < sb ? 32'd1 : 32'd0;
            6'd7: r = longint'(a) < longint'(b) ? 32'd1 : 32'd0;
            6'd8: begin s = longint'(a) * p; r = s[31:0]; end
            6'd9: begin s = longint'(a) / p; r = s[31:0]; end
            6'd10: begin s = sa >= 0 ? sa / p : (sa - p + 1) / p; r = s[31:0]; end
            6'd11: begin s = longint'(a) + longint'(b); r = s[31:0]; end
            6'd12: begin s = longint'(a) - longint'(b); r = s[31:0]; end
            6'd13: begin s = longint'(b) * 65536; r = s[31:0]; end
            default: ;
        endcase
    endfunction

    task automatic test_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) ref_rf[i] = '0;
        for (int i = 0; i < 32; i++) begin
            rf_raddr1 = 5'(i);
            rf_raddr2 = 5'(31 - i);
            #1;
            n_cmp++;
            if (rf_rdata1 !== 32'd0 || rf_rdata2 !== 32'd0) begin
                n_bad++;
                $display("FAIL reset_read r%0d/r%0d: got %h/%h want 0", i, 31 - i, rf_rdata1, rf_rdata2);
            end
        end
        @(negedge clk);
        rf_raddr1 = 5'd0;
        rf_waddr = 5'd0;
        rf_wdata = 32'hDEADBEEF;
        rf_we = 1'b1;
        #1;
        n_cmp++;
        if (rf_rdata1 !== 32'd0) begin
            n_bad++;
            $display("FAIL r0_write_same_cycle: got %h want 0", rf_rdata1);
        end
        @(negedge clk);
        rf_we = 1'b0;
        #1;
        n_cmp++;
        if (rf_rdata1 !== 32'd0) begin
            n_bad++;
            $display("FAIL r0_write_after: got %h want 0", rf_rdata1);
        end
    endtask

    task automatic test_rf_bypass();
        logic [31:0] exp_now;
        @(negedge clk);
        idle();
        rf_we = 1'b1;
        rf_waddr = 5'd5;
        rf_wdata = 32'h12345678;
        rf_raddr1 = 5'd5;
        rf_raddr2 = 5'd5;
        exp_now = BYP ? 32'h12345678 : 32'd0;
        #1;
        n_cmp++;
        if (rf_rdata1 !== exp_now || rf_rdata2 !== exp_now) begin
            n_bad++;
            $display("FAIL r5_same_cycle: got %h/%h want %h", rf_rdata1, rf_rdata2, exp_now);
        end
        @(negedge clk);
        rf_we = 1'b0;
        ref_rf[5] = 32'h12345678;
        #1;
        n_cmp++;
        if (rf_rdata1 !== 32'h12345678 || rf_rdata2 !== 32'h12345678) begin
            n_bad++;
            $display("FAIL r5_after_edge: got %h/%h want 12345678", rf_rdata1, rf_rdata2);
        end
    endtask

    task automatic test_rf_random();
        logic [31:0] e1, e2;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            rf_we = 1'($urandom);
            rf_waddr = 5'($urandom);
            rf_wdata = $urandom;
            rf_raddr1 = $urandom_range(0, 3) == 0 ? rf_waddr : 5'($urandom);
            rf_raddr2 = $urandom_range(0, 3) == 0 ? rf_waddr : 5'($urandom);
            e1 = rf_expect(rf_raddr1);
            e2 = rf_expect(rf_raddr2);
            #1;
            n_cmp++;
            if (rf_rdata1 !== e1 || rf_rdata2 !== e2) begin
                n_bad++;
                $display("FAIL rf_random r%0d/r%0d: got %h/%h want %h/%h",
                         rf_raddr1, rf_raddr2, rf_rdata1, rf_rdata2, e1, e2);
            end
            if (rf_we && rf_waddr != 5'd0) ref_rf[rf_waddr] = rf_wdata;
        end
        @(negedge clk);
        rf_we = 1'b0;
    endtask

    task automatic test_alu();
        logic [5:0] fns [6] = '{6'd0, 6'd1, 6'd6, 6'd7, 6'd10, 6'd63};
        logic [31:0] as [6] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] bs [6] = '{32'd1, 32'd5, 32'd1, 32'd1, 32'd4, 32'hFFFFFFFF};
        logic [31:0] rs [6] = '{32'h80000000, 32'd0, 32'd1, 32'd0, 32'hF8000000, 32'd0};
        logic ovs [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] er;
        logic eo;
        for (int k = 0; k < 6; k++) begin
            alu_fn = fns[k];
            alu_a = as[k];
            alu_b = bs[k];
            #1;
            n_cmp++;
            if (alu_result !== rs[k] || alu_overflow !== ovs[k] || alu_zero !== (rs[k] == 32'd0)) begin
                n_bad++;
                $display("FAIL alu_directed fn=%0d: got %h ov=%b z=%b want %h ov=%b",
                         alu_fn, alu_result, alu_overflow, alu_zero, rs[k], ovs[k]);
            end
        end
        for (int k = 0; k < 300; k++) begin
            alu_fn = $urandom_range(0, 7) == 0 ? 6'($urandom) : 6'($urandom_range(0, 13));
            alu_a = $urandom_range(0, 4) == 0 ? 32'h7FFFFFFF + 32'($urandom_range(0, 2)) : $urandom;
            alu_b = $urandom_range(0, 4) == 0 ? alu_a : $urandom;
            alu_ref(alu_fn, alu_a, alu_b, er, eo);
            #1;
            n_cmp++;
            if (alu_result !== er || alu_overflow !== eo || alu_zero !== (er == 32'd0)) begin
                n_bad++;
                $display("FAIL alu_random fn=%0d a=%h b=%h: got %h ov=%b z=%b want %h ov=%b",
                         alu_fn, alu_a, alu_b, alu_result, alu_overflow, alu_zero, er, eo);
            end
        end
        alu_fn = '0;
    endtask

    task automatic test_mem();
        logic [31:0] e;
        @(negedge clk);
        idle();
        mem_we = 1'b1;
        mem_addr = 32'd10;
        mem_wdata = 32'hCAFEBABE;
        @(negedge clk);
        ref_mem[10] = 32'hCAFEBABE;
        mem_we = 1'b0;
        mem_re = 1'b1;
        #1;
        n_cmp++;
        if (mem_rdata !== 32'hCAFEBABE) begin
            n_bad++;
            $display("FAIL mem_read10: got %h want cafebabe", mem_rdata);
        end
        mem_re = 1'b0;
        #1;
        n_cmp++;
        if (mem_rdata !== 32'd0) begin
            n_bad++;
            $display("FAIL mem_re_low: got %h want 0", mem_rdata);
        end
        mem_re = 1'b1;
        mem_addr = 32'd10 + DEPTH;
        #1;
        n_cmp++;
        if (mem_rdata !== 32'hCAFEBABE) begin
            n_bad++;
            $display("FAIL mem_alias: got %h want cafebabe", mem_rdata);
        end
        @(negedge clk);
        mem_addr = 32'd10;
        mem_we = 1'b1;
        mem_wdata = 32'h11112222;
        #1;
        n_cmp++;
        if (mem_rdata !== 32'hCAFEBABE) begin
            n_bad++;
            $display("FAIL mem_rw_old: got %h want cafebabe", mem_rdata);
        end
        @(negedge clk);
        ref_mem[10] = 32'h11112222;
        mem_we = 1'b0;
        #1;
        n_cmp++;
        if (mem_rdata !== 32'h11112222) begin
            n_bad++;
            $display("FAIL mem_rw_new: got %h want 11112222", mem_rdata);
        end
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            mem_addr = {$urandom_range(0, 7) == 0 ? 22'($urandom) : 22'd0, 10'($urandom_range(0, 15))};
            mem_re = 1'($urandom);
            mem_we = 1'($urandom);
            mem_wdata = $urandom;
            e = mem_re ? ref_mem[mem_addr % DEPTH] : 32'd0;
            #1;
            n_cmp++;
            if (mem_rdata !== e) begin
                n_bad++;
                $display("FAIL mem_random addr=%h re=%b: got %h want %h", mem_addr, mem_re, mem_rdata, e);
            end
            if (mem_we) ref_mem[mem_addr % DEPTH] = mem_wdata;
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        idle();
        rf_we = 1'b1;
        rf_waddr = 5'd3;
        rf_wdata = 32'h33;
        @(negedge clk);
        rst = 1'b1;
        rf_wdata = 32'h3333AAAA;
        mem_we = 1'b1;
        mem_addr = 32'd2;
        mem_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        idle();
        for (int i = 0; i < 32; i++) ref_rf[i] = '0;
        ref_mem[2] = 32'hA5A5A5A5;
        rf_raddr1 = 5'd3;
        mem_addr = 32'd2;
        mem_re = 1'b1;
        #1;
        n_cmp++;
        if (rf_rdata1 !== 32'd0 || mem_rdata !== 32'hA5A5A5A5) begin
            n_bad++;
            $display("FAIL reset_priority: got r3=%h mem2=%h want 0/a5a5a5a5", rf_rdata1, mem_rdata);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            rf_we = 1'b1;
            rf_waddr = 5'(i);
            rf_wdata = 32'(i);
        end
        @(negedge clk);
        rf_we = 1'b0;
        for (int i = 1; i < 32; i++) begin
            rf_raddr1 = 5'(i);
            rf_raddr2 = 5'(32 - i);
            #1;
            n_cmp++;
            if (rf_rdata1 !== 32'(i) || rf_rdata2 !== 32'(32 - i)) begin
                n_bad++;
                $display("FAIL fill r%0d: got %h/%h want %h/%h", i, rf_rdata1, rf_rdata2, i, 32 - i);
            end
        end
        rst = 1'b1;
        rf_we = 1'b1;
        rf_waddr = 5'd7;
        rf_wdata = 32'd77;
        @(negedge clk);
        idle();
        for (int i = 0; i < 32; i++) begin
            rf_raddr1 = 5'(i);
            rf_raddr2 = 5'(i);
            #1;
            n_cmp++;
            if (rf_rdata1 !== 32'd0 || rf_rdata2 !== 32'd0) begin
                n_bad++;
                $display("FAIL reset_mid r%0d: got %h/%h want 0", i, rf_rdata1, rf_rdata2);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        idle();
        test_reset();
        test_rf_bypass();
        test_rf_random();
        test_alu();
        test_mem();
        test_reset_priority();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
